// File: rtl/dmem_responder.sv
// Word-organised data memory behind request/response valid/ready handshakes.
// Each accepted request completes after LATENCY wait states; one transaction in flight.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          IDXW       = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  LAT_L      = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        busy_q;

  logic [31:0] mem_q [DEPTH];

  logic            accept_s;
  logic            exec_s;
  logic            ex_we_s;
  logic [31:0]     ex_addr_s;
  logic [31:0]     ex_wdata_s;
  logic [3:0]      ex_be_s;
  logic            ex_err_s;
  logic [IDXW-1:0] ex_idx_s;
  logic [31:0]     ex_rdata_s;

  // With zero wait states the transaction executes on the acceptance edge,
  // so the live request fields stand in for the not-yet-captured ones.
  assign accept_s   = req_valid && (state_q == ST_IDLE);
  assign exec_s     = (accept_s && (LATENCY == 0)) || ((state_q == ST_WAIT) && (cnt_q == 4'd1));
  assign ex_we_s    = accept_s ? req_we    : we_q;
  assign ex_addr_s  = accept_s ? req_addr  : addr_q;
  assign ex_wdata_s = accept_s ? req_wdata : wdata_q;
  assign ex_be_s    = accept_s ? req_be    : be_q;
  assign ex_err_s   = (ex_addr_s[1:0] != 2'b00) || (ex_addr_s >= ADDR_LIMIT);
  assign ex_idx_s   = ex_addr_s[IDXW+1:2];
  assign ex_rdata_s = (ex_err_s || ex_we_s) ? 32'h0000_0000 : mem_q[ex_idx_s];

  // Next-state and response-data logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = LAT_L;
          if (LATENCY == 0) begin
            state_d = ST_RESP;
            rdata_d = ex_rdata_s;
            err_d   = ex_err_s;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
          rdata_d = ex_rdata_s;
          err_d   = ex_err_s;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured request and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'h0;
      rdata_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Storage array: byte-masked write on the execute edge; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && exec_s && ex_we_s && !ex_err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (ex_be_s[b]) begin
          mem_q[ex_idx_s][8*b +: 8] <= ex_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;

endmodule
